// File: rtl/pipelined_adder_tree_if.sv
// Bundle for the adder tree's input and output streams.
//
// Handshake: a word moves across a stream on a rising clock edge where
// valid and ready are both 1. The sender holds data/valid steady until that edge.
// in_ready comes combinationally from the output side, so the pipeline stalls as one unit.
interface pipelined_adder_tree_if #(
    parameter int N_STAGE  = 5,
    parameter int IN_WIDTH = 2,
    parameter int SUM_W    = IN_WIDTH + N_STAGE
);
    logic [IN_WIDTH*(2**N_STAGE)-1:0] in_data;
    logic                             in_valid;
    logic                             in_ready;
    logic [SUM_W-1:0]                 out_sum;
    logic                             out_valid;
    logic                             out_ready;
    logic                             acc_clear;

    modport master (
        output in_data, in_valid, out_ready, acc_clear,
        input  in_ready, out_sum, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready, acc_clear,
        output in_ready, out_sum, out_valid
    );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Pipelined adder tree. It sums 2**N_STAGE words of IN_WIDTH bits through
// N_STAGE registered stages. Each stage adds adjacent pairs and grows by one bit,
// so the sum is exact. Optional macro ADDER_TREE_ACCUM_EN adds a saturating
// accumulator after the last stage, and out_sum then becomes the accumulator value.
module pipelined_adder_tree #(
    parameter int N_STAGE   = 5,
    parameter int IN_WIDTH  = 2,
    parameter int SIGNED    = 1,
    parameter int ACC_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipelined_adder_tree_if.slave bus
);
    localparam int OUT_W = IN_WIDTH + N_STAGE;

    logic [N_STAGE:1] v;
    logic             adv;
    logic [OUT_W-1:0] tree_sum;

    for (genvar s = 1; s <= N_STAGE; s++) begin : g_stg
        localparam int W   = IN_WIDTH + s;
        localparam int CNT = 2**(N_STAGE - s);

        logic [2*CNT*(W-1)-1:0] prev;
        logic [CNT*W-1:0]       nxt;
        logic [CNT*W-1:0]       q;

        if (s == 1) begin : g_src
            assign prev = bus.in_data;
        end else begin : g_src
            assign prev = g_stg[s-1].q;
        end

        // Add adjacent operand pairs, each extended by one bit (sign or zero)
        always_comb begin
            nxt = '0;
            for (int j = 0; j < CNT; j++) begin
                nxt[j*W +: W] =
                    {(SIGNED != 0) & prev[(2*j)*(W-1) + W-2],   prev[(2*j)*(W-1)   +: W-1]} +
                    {(SIGNED != 0) & prev[(2*j+1)*(W-1) + W-2], prev[(2*j+1)*(W-1) +: W-1]};
            end
        end

        // Stage data register; loads on every advance regardless of valid
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q <= '0;
            end else if (adv) begin
                q <= nxt;
            end
        end
    end

    assign tree_sum     = g_stg[N_STAGE].q;
    assign bus.in_ready = adv;

    // Valid bits shift along with the data whenever the pipe advances
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
        end else if (adv) begin
            v[1] <= bus.in_valid & adv;
            for (int s = 2; s <= N_STAGE; s++) begin
                v[s] <= v[s-1];
            end
        end
    end

`ifdef ADDER_TREE_ACCUM_EN
    logic [ACC_WIDTH-1:0] acc;
    logic                 acc_valid;
    logic                 tree_fire;
    logic [ACC_WIDTH:0]   acc_base;
    logic [ACC_WIDTH:0]   tree_ext;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] acc_nxt;

    assign adv       = !acc_valid || bus.out_ready;
    assign tree_fire = v[N_STAGE] & adv;

    // Saturating add of the extended tree sum; a clear drops the old value first
    always_comb begin
        tree_ext = {{(ACC_WIDTH + 1 - OUT_W){(SIGNED != 0) & tree_sum[OUT_W-1]}}, tree_sum};
        acc_base = bus.acc_clear ? '0 : {(SIGNED != 0) & acc[ACC_WIDTH-1], acc};
        acc_sum  = acc_base + tree_ext;
        acc_nxt  = acc_sum[ACC_WIDTH-1:0];
        if (SIGNED != 0) begin
            if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1]) begin
                acc_nxt = acc_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (acc_sum[ACC_WIDTH]) begin
            acc_nxt = '1;
        end
    end

    // Accumulator and its output valid, one stage after the tree
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            acc_valid <= 1'b0;
        end else begin
            if (adv) begin
                acc_valid <= v[N_STAGE];
            end
            if (tree_fire) begin
                acc <= acc_nxt;
            end else if (bus.acc_clear) begin
                acc <= '0;
            end
        end
    end

    assign bus.out_sum   = acc;
    assign bus.out_valid = acc_valid;
`else
    logic unused_acc_clear;

    assign adv              = !v[N_STAGE] || bus.out_ready;
    assign unused_acc_clear = bus.acc_clear;
    assign bus.out_sum      = tree_sum;
    assign bus.out_valid    = v[N_STAGE];
`endif
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree. It runs a signed and an unsigned instance side by side
// on the same stimulus. Expected sums come from plain arithmetic over the input words.
// Expected timing comes from counting pipeline advances since each word was accepted.
module tb_pipelined_adder_tree;
    localparam int N   = 5;
    localparam int IW  = 2;
    localparam int NUM = 32;
    localparam int DW  = IW * NUM;
    localparam int OW  = IW + N;
`ifdef ADDER_TREE_ACCUM_EN
    localparam int AW  = 8;
    localparam int SW  = AW;
    localparam int LAT = N + 1;
`else
    localparam int AW  = 16;
    localparam int SW  = OW;
    localparam int LAT = N;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          out_ready;
    logic          acc_clear;

    pipelined_adder_tree_if #(.N_STAGE(N), .IN_WIDTH(IW), .SUM_W(SW)) bus_s ();
    pipelined_adder_tree_if #(.N_STAGE(N), .IN_WIDTH(IW), .SUM_W(SW)) bus_u ();

    assign bus_s.in_data   = in_data;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.out_ready = out_ready;
    assign bus_s.acc_clear = acc_clear;
    assign bus_u.in_data   = in_data;
    assign bus_u.in_valid  = in_valid;
    assign bus_u.out_ready = out_ready;
    assign bus_u.acc_clear = acc_clear;

    pipelined_adder_tree #(.N_STAGE(N), .IN_WIDTH(IW), .SIGNED(1), .ACC_WIDTH(AW)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s));
    pipelined_adder_tree #(.N_STAGE(N), .IN_WIDTH(IW), .SIGNED(0), .ACC_WIDTH(AW)) dut_u (
        .clk(clk), .reset(reset), .bus(bus_u));

    // scoreboard
    logic [SW-1:0] exp_s_q[$];
    logic [SW-1:0] exp_u_q[$];
    int            tag_q[$];
    int            adv_cnt;
    int            acc_s;
    int            acc_u;
    bit            clr_with_next;
    bit            last_acc;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_sum(input logic [DW-1:0] d, input bit sgn);
        int s;
        logic [IW-1:0] w;
        s = 0;
        for (int k = 0; k < NUM; k++) begin
            w = d[k*IW +: IW];
            s += sgn ? int'($signed(w)) : int'(w);
        end
        return s;
    endfunction

    function automatic int sat_s(input int x);
        int hi, lo;
        hi = (1 << (AW - 1)) - 1;
        lo = -(1 << (AW - 1));
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    function automatic int sat_u(input int x);
        int hi;
        hi = (1 << AW) - 1;
        return (x > hi) ? hi : x;
    endfunction

    task automatic push_word(input logic [DW-1:0] d);
        int ts, tu;
        ts = ref_sum(d, 1'b1);
        tu = ref_sum(d, 1'b0);
`ifdef ADDER_TREE_ACCUM_EN
        if (clr_with_next) begin
            acc_s = 0;
            acc_u = 0;
            clr_with_next = 1'b0;
        end
        acc_s = sat_s(acc_s + ts);
        acc_u = sat_u(acc_u + tu);
        exp_s_q.push_back(SW'(acc_s));
        exp_u_q.push_back(SW'(acc_u));
`else
        exp_s_q.push_back(SW'(ts));
        exp_u_q.push_back(SW'(tu));
`endif
        tag_q.push_back(adv_cnt + 1);
    endtask

    // one cycle: inputs already driven at negedge; check, book-keep, advance
    task automatic tick();
        bit head_rdy, adv_m;
        #1;
        head_rdy = (tag_q.size() != 0) && (adv_cnt - tag_q[0] >= LAT - 1);
        adv_m    = !head_rdy || out_ready;
        chk("out_valid_s", bus_s.out_valid, head_rdy);
        chk("out_valid_u", bus_u.out_valid, head_rdy);
        chk("in_ready_s", bus_s.in_ready, adv_m);
        chk("in_ready_u", bus_u.in_ready, adv_m);
        if (head_rdy) begin
            chk("sum_s", bus_s.out_sum, exp_s_q[0]);
            chk("sum_u", bus_u.out_sum, exp_u_q[0]);
            if (out_ready) begin
                void'(exp_s_q.pop_front());
                void'(exp_u_q.pop_front());
                void'(tag_q.pop_front());
            end
        end
        last_acc = in_valid && adv_m;
        if (last_acc) push_word(in_data);
        if (adv_m) adv_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // driver: present one word until accepted
    task automatic send(input logic [DW-1:0] d);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        chk("send_accept", last_acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (tag_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("drain_empty", tag_q.size(), 0);
    endtask

    task automatic clear_model();
        exp_s_q.delete();
        exp_u_q.delete();
        tag_q.delete();
        adv_cnt = 0;
        acc_s = 0;
        acc_u = 0;
        clr_with_next = 1'b0;
    endtask

    logic [DW-1:0] d;
    int            sent;
    int            t;

    initial begin
        checks = 0;
        errors = 0;
        clear_model();
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        acc_clear = 1'b0;
        #1;
        chk("rst_out_valid_s", bus_s.out_valid, 0);
        chk("rst_out_sum_s", bus_s.out_sum, 0);
        chk("rst_out_valid_u", bus_u.out_valid, 0);
        chk("rst_out_sum_u", bus_u.out_sum, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // all -2 (signed -64), then all 3 and all 1 back to back
        in_data = {NUM{2'b10}}; in_valid = 1'b1; tick();
        in_data = {NUM{2'b11}}; tick();
        in_data = {NUM{2'b01}}; tick();
        in_valid = 1'b0;
        drain();

        // alternating +1 / -1
        send({(NUM/2){2'b11, 2'b01}});
        drain();

        // one-hot +1 swept over every position, back to back
        for (int k = 0; k < NUM; k++) begin
            d = '0;
            d[k*IW +: IW] = 2'b01;
            in_data  = d;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();

        // 8 words with a 3-cycle output stall in the middle
        sent = 0;
        t = 0;
        while (sent < 8 && t < 40) begin
            in_data   = {$urandom, $urandom};
            in_valid  = 1'b1;
            out_ready = (t >= 6 && t <= 8) ? 1'b0 : 1'b1;
            tick();
            if (last_acc) sent++;
            t++;
        end
        chk("stall_sent", sent, 8);
        drain();

        // reset with 3 words in flight
        for (int k = 0; k < 3; k++) begin
            in_data  = {$urandom, $urandom};
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid_s", bus_s.out_valid, 0);
        chk("midrst_out_valid_u", bus_u.out_valid, 0);
        chk("midrst_out_sum_s", bus_s.out_sum, 0);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        repeat (8) tick();
        send({NUM{2'b01}});
        drain();

        // randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_data   = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // accumulator: clear while idle, then 4 words of +32, then clear with -5
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        acc_s = 0;
        acc_u = 0;
        for (int k = 0; k < 4; k++) send({NUM{2'b01}});
        drain();
        d = '0;
        d[IW-1:0]      = 2'b10;
        d[2*IW-1:IW]   = 2'b10;
        d[3*IW-1:2*IW] = 2'b11;
        clr_with_next = 1'b1;
        send(d);
        repeat (LAT - 2) tick();
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
